// File: rtl/dc_bsp_pkg.sv
// Shared BSP types and constants for the kernel-side AVMM write-ack path.
// Holds the expander FSM encoding and the default FIFO sizing.
package dc_bsp_pkg;

   localparam int LOCAL_MEM_BURST_CNT_WIDTH  = 7;
   localparam int WR_ACK_EXPANDER_FIFO_DEPTH = 16;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } write_ack_state;

   function automatic int fifo_cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/avmm_wr_ack_burst_fifo.sv
// Single-clock show-ahead FIFO holding pending burst-ack beat counts.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module avmm_wr_ack_burst_fifo
   import dc_bsp_pkg::*;
#(
   parameter int WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
   parameter int DEPTH = WR_ACK_EXPANDER_FIFO_DEPTH,
   parameter int CW    = fifo_cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] data,
   input  logic             pop,
   output logic [WIDTH-1:0] first,
   output logic             notEmpty,
   output logic             notFull,
   output logic [CW-1:0]    count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign notEmpty = (count != '0);
   assign notFull  = (count != CNT_FULL);
   assign first    = mem[rd_ptr];

   // The slot freed by a same-cycle pop is the one the push lands in.
   assign do_pop  = pop & notEmpty;
   assign do_push = push & (notFull | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/avmm_wr_ack_expander.sv
// Expands per-burst write acks into per-beat kernel writeack pulses.
// Optional pending_beats output: AVMM_WR_ACK_EXPANDER_PENDING_CNT_EN.
module avmm_wr_ack_expander
   import dc_bsp_pkg::*;
#(
   parameter int AVMM_BURSTCNT_WIDTH = LOCAL_MEM_BURST_CNT_WIDTH,
   parameter int ACK_FIFO_DEPTH      = WR_ACK_EXPANDER_FIFO_DEPTH
) (
   input  logic                           kernel_avmm_clk,
   input  logic                           kernel_avmm_reset_n,
   input  logic                           burst_wr_ack,
   input  logic [AVMM_BURSTCNT_WIDTH-1:0] burst_wr_ack_burstcnt,
   output logic                           kernel_avmm_writeack,
   output logic [$clog2(ACK_FIFO_DEPTH):0] ack_fifo_count,
   output logic                           ack_fifo_overflow,
   output logic                           zero_burstcnt_err
`ifdef AVMM_WR_ACK_EXPANDER_PENDING_CNT_EN
   ,
   output logic [31:0]                    pending_beats
`endif
);

   localparam int W  = AVMM_BURSTCNT_WIDTH;
   localparam int CW = $clog2(ACK_FIFO_DEPTH) + 1;
   localparam logic [W-1:0] BEAT_ONE = W'(1);

   write_ack_state state_q;
   write_ack_state state_d;
   logic [W-1:0]   beats_left;
   logic [W-1:0]   beats_d;

   logic           push_req;
   logic           push_ok;
   logic           fifo_pop;
   logic [W-1:0]   fifo_first;
   logic           fifo_not_empty;
   logic           fifo_not_full;
   logic [CW-1:0]  fifo_count;

   assign push_req = burst_wr_ack & (burst_wr_ack_burstcnt != '0);
   assign push_ok  = push_req & (fifo_not_full | fifo_pop);

   avmm_wr_ack_burst_fifo #(
      .WIDTH (W),
      .DEPTH (ACK_FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk      (kernel_avmm_clk),
      .rst_n    (kernel_avmm_reset_n),
      .push     (push_req),
      .data     (burst_wr_ack_burstcnt),
      .pop      (fifo_pop),
      .first    (fifo_first),
      .notEmpty (fifo_not_empty),
      .notFull  (fifo_not_full),
      .count    (fifo_count)
   );

   assign ack_fifo_count       = fifo_count;
   assign kernel_avmm_writeack = (state_q == ST_EXPAND);

   // Reload on the last beat keeps consecutive bursts gap-free.
   always_comb begin
      state_d  = state_q;
      beats_d  = beats_left;
      fifo_pop = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (fifo_not_empty) begin
               fifo_pop = 1'b1;
               beats_d  = fifo_first;
               state_d  = ST_EXPAND;
            end
         end
         ST_EXPAND: begin
            if (beats_left == BEAT_ONE) begin
               if (fifo_not_empty) begin
                  fifo_pop = 1'b1;
                  beats_d  = fifo_first;
               end else begin
                  beats_d = '0;
                  state_d = ST_IDLE;
               end
            end else begin
               beats_d = beats_left - BEAT_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         state_q    <= ST_IDLE;
         beats_left <= '0;
      end else begin
         state_q    <= state_d;
         beats_left <= beats_d;
      end
   end

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         ack_fifo_overflow <= 1'b0;
         zero_burstcnt_err <= 1'b0;
      end else begin
         if (push_req && !fifo_not_full && !fifo_pop) begin
            ack_fifo_overflow <= 1'b1;
         end
         if (burst_wr_ack && (burst_wr_ack_burstcnt == '0)) begin
            zero_burstcnt_err <= 1'b1;
         end
      end
   end

`ifdef AVMM_WR_ACK_EXPANDER_PENDING_CNT_EN
   logic [31:0] add_beats;
   logic [31:0] sub_beats;

   assign add_beats = push_ok ? 32'(burst_wr_ack_burstcnt) : 32'd0;
   assign sub_beats = 32'(kernel_avmm_writeack);

   always_ff @(posedge kernel_avmm_clk or negedge kernel_avmm_reset_n) begin
      if (!kernel_avmm_reset_n) begin
         pending_beats <= '0;
      end else begin
         pending_beats <= pending_beats + add_beats - sub_beats;
      end
   end
`endif

endmodule

// File: doc/avmm_wr_ack_expander.md
# avmm_wr_ack_expander

Converts the per-burst write-acknowledge produced by the write-ack tracker (one pulse plus that burst's burstcount) into the per-beat writeack stream the kernel AVMM interface expects. It sits directly downstream of the tracker in the kernel clock domain. It buffers pending burst acks in a small FIFO because the tracker cannot be back-pressured. It then emits exactly `burstcnt` consecutive single-cycle writeack pulses per buffered entry.

## Interface
- `AVMM_BURSTCNT_WIDTH`, default `LOCAL_MEM_BURST_CNT_WIDTH`: width of the burstcount field.
- `ACK_FIFO_DEPTH`, default 16: number of pending burst acks buffered; must be a power of 2, ≥2.
- `kernel_avmm_clk` in 1: sole clock.
- `kernel_avmm_reset_n` in 1: one clock; reset is asynchronous and active-low.
- `burst_wr_ack` in 1: one-cycle pulse, one per completed burst.
- `burst_wr_ack_burstcnt` in `AVMM_BURSTCNT_WIDTH`: beat count of that burst; valid when `burst_wr_ack`=1.
- `kernel_avmm_writeack` out 1: per-beat write acknowledge.
- `ack_fifo_count` out `$clog2(ACK_FIFO_DEPTH)+1`: entries currently buffered.
- `ack_fifo_overflow` out 1: sticky; an ack was dropped because the FIFO was full.
- `zero_burstcnt_err` out 1: sticky; a burst ack arrived with burstcnt 0.

## Operation
- Push: `burst_wr_ack`=1 with burstcnt≠0 enqueues burstcnt.
  - If burstcnt=0, nothing is enqueued and `zero_burstcnt_err` is set.
- FSM states: ST_IDLE and ST_EXPAND. A beat counter `beats_left` is `AVMM_BURSTCNT_WIDTH` wide.
- ST_IDLE with FIFO non-empty:
  - pop the entry;
  - load `beats_left` with burstcnt;
  - go to ST_EXPAND.
- ST_EXPAND:
  - `kernel_avmm_writeack`=1 in every cycle while in ST_EXPAND; it is decoded directly from the state flop.
  - `beats_left` decrements each cycle.
- ST_EXPAND with `beats_left`=1 (last beat):
  - if the FIFO is non-empty, pop and reload `beats_left` in the same cycle and stay in ST_EXPAND. There is no bubble between bursts.
  - otherwise go to ST_IDLE.
- Full FIFO with a push and no simultaneous pop: the push is dropped, `ack_fifo_overflow` is set, and the stored contents are unchanged.
- Full FIFO with a push and a simultaneous pop: both are performed and the count is unchanged.
- Empty FIFO with a push while idle: the entry is written. It is popped no earlier than the following cycle; there is no write-through bypass.
- Sticky flags clear only on reset.
- Burstcnt equal to the maximum encodable value (all ones) is legal and yields 2^W−1 pulses. There is no wrap: the counter never decrements below 1 before reload or exit.

## Timing
- Reset is asynchronous. On assertion, the following take effect immediately:
  - `kernel_avmm_writeack`=0, `ack_fifo_count`=0;
  - `ack_fifo_overflow`=0, `zero_burstcnt_err`=0;
  - state ST_IDLE, `beats_left`=0.
- Reset assertion mid-burst discards all pending beats and buffered entries.
- Deassertion is synchronised externally. The first legal push is the first edge after deassertion.
- Latency from idle: `burst_wr_ack` at cycle T gives writeack high from T+2 to T+1+N, where N is the burstcnt.
- Throughput: one writeack per cycle sustained. A continuous FIFO supply gives 100% writeack duty.
- `ack_fifo_count` is registered and reflects pushes/pops of the previous edge.

## Configuration
- `AVMM_WR_ACK_EXPANDER_PENDING_CNT_EN`: when defined, adds an output `pending_beats`, 32 bits wide.
  - It is the sum of unemitted beats, buffered plus in-flight.
  - It increments by burstcnt on accepted push and decrements by 1 per writeack, with a simultaneous push and decrement netted in one update.
  - Reset value is 0.
- Without the macro the port and its adder are absent; all other behaviour is identical.

## Structure
- `write_ack_state` enum and default depth constant `WR_ACK_EXPANDER_FIFO_DEPTH`=16 belong in `dc_bsp_pkg`.
- One sub-module: `avmm_wr_ack_burst_fifo`.
  - Single-clock, show-ahead FIFO with async active-low reset.
  - Ports: push, data, pop, first, notEmpty, notFull, count.
- Overflow and zero-count detection plus the FSM live in the top module.

## Test plan
- Single burst: reset, push burstcnt=4 at T → writeack high T+2..T+5, low at T+6; count returns to 0.
- Back-to-back: push burstcnt 3 then 2 on consecutive cycles → 5 contiguous writeack cycles, no gap.
- Overflow: hold expander busy with a burst of 100 beats, then push 17 entries (depth 16) → 17th dropped and `ack_fifo_overflow`=1. Total writeacks equal 100 plus the sum of the 16 accepted entries.
- Full plus simultaneous pop: FIFO full, push on the cycle of a pop → entry accepted, no overflow, count stays 16.
- Zero burst: push burstcnt=0 → no writeack, count stays 0, `zero_burstcnt_err`=1. A following burstcnt=1 gives exactly one pulse.
- Async reset mid-burst: reset asserted during beat 2 of 8 → writeack low before the next edge, all counters 0. After release, a new push of 2 gives exactly 2 pulses. With `AVMM_WR_ACK_EXPANDER_PENDING_CNT_EN`, `pending_beats` reads 0 then 2.
